// File: rtl/wb_spram_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter placed in front of a
// single-port RAM. Round-robin grant, ownership locked for a whole cyc tenure,
// and an outstanding-strobe counter that throttles the owner so no more than
// MAX_OUTSTANDING requests are ever awaiting a response.
module wb_spram_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic [DATA_WIDTH-1:0]   m0_dat_w,
    output logic [DATA_WIDTH-1:0]   m0_dat_r,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic                    m0_stall,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic [DATA_WIDTH-1:0]   m1_dat_w,
    output logic [DATA_WIDTH-1:0]   m1_dat_r,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic                    m1_stall,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic [DATA_WIDTH-1:0]   s_dat_w,
    input  logic [DATA_WIDTH-1:0]   s_dat_r,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic                    s_stall
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 last_grant;
    logic                 last_grant_next;
    logic [CNT_WIDTH-1:0] outstanding;
    logic [CNT_WIDTH-1:0] outstanding_next;
    logic                 full;
    logic                 accept;
    logic                 resp;

    assign full   = (outstanding == CNT_WIDTH'(MAX_OUTSTANDING));
    assign accept = s_stb & ~s_stall;
    assign resp   = s_ack | s_err;

    // Read data is broadcast; only the owner's ack qualifies it.
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // State, round-robin pointer and outstanding counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            outstanding <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            state       <= state_next;
            last_grant  <= last_grant_next;
            outstanding <= outstanding_next;
        end
    end

    // Next-state: arbitrate from IDLE, hold ownership until the owner drops cyc.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        state_next      = state;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last_grant)) begin
                    state_next      = OWN0;
                    last_grant_next = 1'b0;
                end else if (m1_cyc) begin
                    state_next      = OWN1;
                    last_grant_next = 1'b1;
                end
            end
            OWN0:    if (!m0_cyc) state_next = IDLE;
            OWN1:    if (!m1_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outstanding count: cleared whenever no tenure is active or one is ending,
    // so responses to an aborted cycle can never be credited to the next owner.
    always_comb begin
        outstanding_next = outstanding;
        if (state == IDLE || state_next == IDLE) begin
            outstanding_next = '0;
        end else if (accept && !(resp && outstanding != '0)) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!accept && resp && outstanding != '0) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // Output decode: forward the owner to the slave, park the other master.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_w  = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = 1'b1;
        unique case (state)
            OWN0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_w  = m0_dat_w;
                m0_stall = s_stall | full;
                m0_ack   = s_ack;
                m0_err   = s_err;
            end
            OWN1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_w  = m1_dat_w;
                m1_stall = s_stall | full;
                m1_ack   = s_ack;
                m1_err   = s_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_spram_arbiter.sv
// Directed bench for wb_spram_arbiter. u_a (MAX_OUTSTANDING=2) sits in front
// of a zero-stall, one-cycle-ack RAM model; u_b (MAX_OUTSTANDING=1) sits in
// front of a slave that acks three cycles after acceptance.
module tb_wb_spram_arbiter;

    logic        clk;
    logic        rst_n;

    // u_a signals
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic [3:0]  m0_sel;
    logic        m0_ack, m0_err, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic [3:0]  m1_sel;
    logic        m1_ack, m1_err, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_stall;

    // u_b signals
    logic        b_m0_cyc, b_m0_stb, b_m0_we;
    logic [31:0] b_m0_adr, b_m0_dat_w, b_m0_dat_r;
    logic [3:0]  b_m0_sel;
    logic        b_m0_ack, b_m0_err, b_m0_stall;
    logic        b_m1_cyc, b_m1_stb, b_m1_we;
    logic [31:0] b_m1_adr, b_m1_dat_w, b_m1_dat_r;
    logic [3:0]  b_m1_sel;
    logic        b_m1_ack, b_m1_err, b_m1_stall;
    logic        b_s_cyc, b_s_stb, b_s_we;
    logic [31:0] b_s_adr, b_s_dat_w, b_s_dat_r;
    logic [3:0]  b_s_sel;
    logic        b_s_ack, b_s_err, b_s_stall;

    logic [31:0] mem [0:15];
    logic [2:0]  b_pipe;

    int checks = 0;
    int errors = 0;

    wb_spram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
    );

    wb_spram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(b_m0_cyc), .m0_stb(b_m0_stb), .m0_we(b_m0_we), .m0_adr(b_m0_adr),
        .m0_sel(b_m0_sel), .m0_dat_w(b_m0_dat_w), .m0_dat_r(b_m0_dat_r),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_stall(b_m0_stall),
        .m1_cyc(b_m1_cyc), .m1_stb(b_m1_stb), .m1_we(b_m1_we), .m1_adr(b_m1_adr),
        .m1_sel(b_m1_sel), .m1_dat_w(b_m1_dat_w), .m1_dat_r(b_m1_dat_r),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_stall(b_m1_stall),
        .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
        .s_sel(b_s_sel), .s_dat_w(b_s_dat_w), .s_dat_r(b_s_dat_r),
        .s_ack(b_s_ack), .s_err(b_s_err), .s_stall(b_s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model for u_a: preloaded on reset, byte-lane writes, registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i < 4) ? 32'hA0 + 32'(i) : 32'h0;
            s_dat_r <= 32'h0;
        end else if (s_cyc && s_stb && !s_stall) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
            end else begin
                s_dat_r <= mem[s_adr[5:2]];
            end
        end
    end

    // One-cycle ack for u_a's RAM; deliberately not reset so a pending ack
    // is still on the bus while the arbiter itself is being reset.
    always @(posedge clk) s_ack <= s_cyc & s_stb & ~s_stall;

    // Slow slave for u_b: ack three cycles after the accepting cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_pipe <= 3'b000;
        else        b_pipe <= {b_pipe[1:0], b_s_cyc & b_s_stb & ~b_s_stall};
    end
    assign b_s_ack = b_pipe[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic idx, input logic cyc, input logic stb);
        if (idx) begin m1_cyc = cyc; m1_stb = stb; end
        else     begin m0_cyc = cyc; m0_stb = stb; end
    endtask

    // Every ack delivered to a u_a master must answer a pending request.
    always @(negedge clk)
        if (rst_n && (m0_ack || m1_ack))
            check("ack_pending", 32'(u_a.outstanding != '0), 32'd1);

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic own;
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_sel = 4'hF; m0_dat_w = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_sel = 4'hF; m1_dat_w = 0;
        s_err = 0; s_stall = 0;
        b_m0_cyc = 0; b_m0_stb = 0; b_m0_we = 0; b_m0_adr = 0; b_m0_sel = 4'hF; b_m0_dat_w = 0;
        b_m1_cyc = 0; b_m1_stb = 0; b_m1_we = 0; b_m1_adr = 0; b_m1_sel = 4'hF; b_m1_dat_w = 0;
        b_s_err = 0; b_s_stall = 0; b_s_dat_r = 32'hB0B0_0001;

        // ---- reset values ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_cyc",    s_cyc,    0);
        check("rst_s_stb",    s_stb,    0);
        check("rst_m0_ack",   m0_ack,   0);
        check("rst_m0_err",   m0_err,   0);
        check("rst_m1_ack",   m1_ack,   0);
        check("rst_stalls",   {m0_stall, m1_stall}, 2'b11);
        check("rst_outst",    u_a.outstanding, 0);
        rst_n = 1'b1;

        // ---- single-master burst: reads 0x0..0xC ----
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0;
        @(negedge clk);
        check("burst_arb_stall", m0_stall, 1);
        check("burst_arb_scyc",  s_cyc,    0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i < 4) m0_adr = 32'(i * 4);
            else       m0_stb = 0;
            @(negedge clk);
            if (i < 4) check("burst_stall", m0_stall, 0);
            check("burst_ack", m0_ack, 32'(i > 0));
            if (i > 0) check("burst_dat", m0_dat_r, 32'hA0 + 32'(i) - 1);
        end
        @(posedge clk); #1; m0_cyc = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("burst_end_outst", u_a.outstanding, 0);

        // ---- reset while OWN1 with one response pending ----
        @(posedge clk); #1;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h4;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_own1_stall", m1_stall, 0);
        @(posedge clk); #1; m1_stb = 0;
        check("mrst_pre_ack",   m1_ack, 1);
        check("mrst_pre_outst", u_a.outstanding, 1);
        rst_n = 1'b0; #1;
        check("mrst_s_cyc",    s_cyc,    0);
        check("mrst_m1_stall", m1_stall, 1);
        check("mrst_m1_ack",   m1_ack,   0);
        check("mrst_outst",    u_a.outstanding, 0);
        m1_cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- contention from reset: m0 first, then m1 partial write ----
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h4;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h10; m1_sel = 4'b0011; m1_dat_w = 32'h1234_5678;
        @(negedge clk);
        check("cont_idle_stall", {m0_stall, m1_stall}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        check("cont_grant0", {m0_stall, m1_stall}, 2'b01);
        check("cont_adr",    s_adr, 32'h4);
        @(posedge clk); #1; m0_stb = 0;
        @(negedge clk);
        check("cont_m0_ack",   m0_ack,   1);
        check("cont_m0_dat",   m0_dat_r, 32'hA1);
        check("cont_m1_wait",  {m1_stall, m1_ack}, 2'b10);
        @(posedge clk); #1; m0_cyc = 0;
        @(negedge clk);
        check("cont_m1_wait2", m1_stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("cont_idle2", {s_cyc, m1_stall}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        check("cont_grant1",  m1_stall, 0);
        check("cont_s_we",    s_we,     1);
        check("cont_s_sel",   s_sel,    4'b0011);
        check("cont_s_dat_w", s_dat_w,  32'h1234_5678);
        @(posedge clk); #1; m1_stb = 0;
        @(negedge clk);
        check("cont_m1_ack", m1_ack, 1);
        check("cont_mem",    mem[4], 32'h0000_5678);
        @(posedge clk); #1; m1_cyc = 0; m1_we = 0; m1_sel = 4'hF;
        @(posedge clk); #1;

        // ---- round-robin under continuous contention (last grant was m1) ----
        m0_adr = 32'h0; m1_adr = 32'h8;
        set_req(1'b0, 1'b1, 1'b1);
        set_req(1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            own = 1'(t % 2);
            @(negedge clk);
            check("rr_idle_stall", {m0_stall, m1_stall}, 2'b11);
            @(posedge clk); #1;
            @(negedge clk);
            check("rr_grant", {m0_stall, m1_stall}, own ? 2'b10 : 2'b01);
            @(posedge clk); #1; set_req(own, 1'b1, 1'b0);
            @(negedge clk);
            check("rr_ack", {m0_ack, m1_ack}, own ? 2'b01 : 2'b10);
            check("rr_dat", own ? m1_dat_r : m0_dat_r, own ? 32'hA2 : 32'hA0);
            @(posedge clk); #1; set_req(own, 1'b0, 1'b0);
            @(posedge clk); #1; set_req(own, 1'b1, 1'b1);
        end
        set_req(1'b0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // ---- u_b: outstanding limit of 1 with a 3-cycle ack ----
        @(posedge clk); #1;
        b_m0_cyc = 1; b_m0_stb = 1; b_m0_adr = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("lim_first_stall", b_m0_stall, 0);
        check("lim_first_stb",   b_s_stb,    1);
        check("lim_first_outst", u_b.outstanding, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("lim_full_stall", b_m0_stall, 1);
            check("lim_full_stb",   b_s_stb,    0);
            check("lim_full_outst", u_b.outstanding, 1);
            check("lim_ack",        b_m0_ack, 32'(k == 2));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("lim_drain_outst", u_b.outstanding, 0);
        check("lim_next_stall",  b_m0_stall, 0);
        check("lim_next_stb",    b_s_stb,    1);

        // ---- u_b: abort the second read the cycle after it is accepted ----
        @(posedge clk); #1; b_m0_cyc = 0; b_m0_stb = 0;
        @(negedge clk);
        check("abort_pending", u_b.outstanding, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle_outst", u_b.outstanding, 0);
        check("abort_idle_scyc",  b_s_cyc, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_late_sack",  b_s_ack, 1);
        check("abort_late_acks",  {b_m0_ack, b_m1_ack}, 2'b00);
        check("abort_late_outst", u_b.outstanding, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
